program_ram_loader: RTL and testbench

Writable 16×16-bit instruction memory with a byte-serial loader front end. It replaces the fixed-contents program store. An external host streams a program in as bytes over a valid/ready handshake, and the processor fetches from the combinational read port. While a load is in progress, the block holds the processor off with `cpu_hold`.

---
 rtl/program_ram_loader.sv | 125 ++++++++++++
 tb/tb_program_ram_loader.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_ram_loader.sv
// Writable 16x16 instruction store with a byte-serial (high byte first) loader.
// The processor reads combinationally; cpu_hold stalls it while a load runs.
//
// state  | meaning
// -------+-------------------------------------------------
// IDLE   | no load active; start/load_count sampled here
// GET_HI | waiting for the high byte of the current word
// GET_LO | waiting for the low byte; word written on accept
module program_ram_loader #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [4:0]  load_count,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        busy,
    output logic        cpu_hold,
    output logic        done,
    input  logic [3:0]  rd_addr,
    output logic [15:0] rd_instr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GET_HI = 2'd1,
        GET_LO = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  wr_addr;
    logic [4:0]  remaining;
    logic [7:0]  hi_reg;
    logic        done_q;
    logic        done_next;
    logic        load_start;
    logic        hi_take;
    logic        word_write;
    logic [15:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        load_start = 1'b0;
        hi_take    = 1'b0;
        word_write = 1'b0;
        byte_ready = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load_start = 1'b1;
                    if (load_count == 5'd0) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = GET_HI;
                    end
                end
            end
            GET_HI: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    hi_take    = 1'b1;
                    state_next = GET_LO;
                end
            end
            GET_LO: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    word_write = 1'b1;
                    if (remaining == 5'd1) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = GET_HI;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Loader datapath; reset also wipes the program so a torn load never executes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr   <= 4'd0;
            remaining <= 5'd0;
            hi_reg    <= 8'd0;
            done_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 16'h0000;
            end
        end else begin
            done_q <= done_next;
            if (load_start) begin
                remaining <= load_count;
                wr_addr   <= 4'd0;
            end
            if (hi_take) begin
                hi_reg <= byte_in;
            end
            if (word_write) begin
                mem[wr_addr] <= {hi_reg, byte_in};
                wr_addr      <= wr_addr + 4'd1;
                remaining    <= remaining - 5'd1;
            end
        end
    end

    assign busy     = (state != IDLE);
    assign cpu_hold = busy;
    assign done     = done_q;
    assign rd_instr = mem[rd_addr];

endmodule

// File: tb/tb_program_ram_loader.sv
// Randomized bench for program_ram_loader: a byte-count model predicts outputs
// every cycle, and directed scenarios pin the model with literal expectations.
module tb_program_ram_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  load_count = 5'd0;
    logic [7:0]  byte_in = 8'd0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        busy;
    logic        cpu_hold;
    logic        done;
    logic [3:0]  rd_addr = 4'd0;
    logic [15:0] rd_instr;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;
    bit sweeping = 1'b0;
    int hold_cnt = 0;
    int done_cnt = 0;
    int hs_cnt = 0;

    // Model: a load is a run of 2*count bytes; every odd byte completes a word.
    bit          m_active = 1'b0;
    int          m_need = 0;
    int          m_got = 0;
    bit          m_done = 1'b0;
    logic [7:0]  m_hi = 8'd0;
    logic [15:0] m_mem [16];

    logic [15:0] wbuf [16];
    logic [15:0] save [16];

    program_ram_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .load_count (load_count),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .busy       (busy),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .rd_addr    (rd_addr),
        .rd_instr   (rd_instr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_need   <= 0;
            m_got    <= 0;
            m_done   <= 1'b0;
            m_hi     <= 8'd0;
            for (int i = 0; i < 16; i++) m_mem[i] <= 16'h0000;
        end else begin
            m_done <= 1'b0;
            if (!m_active) begin
                if (start) begin
                    if (load_count == 5'd0) begin
                        m_done <= 1'b1;
                    end else begin
                        m_active <= 1'b1;
                        m_need   <= 2 * int'(load_count);
                        m_got    <= 0;
                    end
                end
            end else if (byte_valid) begin
                if (m_got % 2 == 0) m_hi <= byte_in;
                else m_mem[4'(m_got / 2)] <= {m_hi, byte_in};
                m_got <= m_got + 1;
                if (m_got + 1 == m_need) begin
                    m_active <= 1'b0;
                    m_done   <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", 32'(busy), 32'(m_active));
            chk("cpu_hold", 32'(cpu_hold), 32'(m_active));
            chk("byte_ready", 32'(byte_ready), 32'(m_active));
            chk("done", 32'(done), 32'(m_done));
            chk("rd_instr", 32'(rd_instr), 32'(m_mem[rd_addr]));
            if (busy) hold_cnt++;
            if (done) done_cnt++;
            if (byte_valid && byte_ready) hs_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (!sweeping) rd_addr = 4'($urandom);
    endtask

    task automatic do_start(input int n);
        start = 1'b1;
        load_count = 5'(n);
        tick();
        start = 1'b0;
        load_count = 5'($urandom);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit poke);
        repeat (gap) begin
            byte_valid = 1'b0;
            byte_in = 8'($urandom);
            tick();
        end
        byte_valid = 1'b1;
        byte_in = b;
        if (poke) begin
            start = 1'b1;
            load_count = 5'd5;
        end
        tick();
        byte_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        if (busy) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic load(input int n, input int gap, input bit poke);
        do_start(n);
        for (int i = 0; i < n; i++) begin
            send_byte(wbuf[i][15:8], (i == 0) ? 0 : gap, poke && (i == 0));
            send_byte(wbuf[i][7:0], gap, 1'b0);
        end
        wait_idle();
    endtask

    task automatic peek(input int a, input logic [15:0] exp, input string name);
        sweeping = 1'b1;
        rd_addr = 4'(a);
        #1;
        chk(name, 32'(rd_instr), 32'(exp));
        sweeping = 1'b0;
    endtask

    task automatic clr_counts();
        hold_cnt = 0;
        done_cnt = 0;
        hs_cnt = 0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        cmp_en = 1'b1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(byte_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        for (int a = 0; a < 16; a += 5) peek(a, 16'h0000, "rst_mem");
        tick();
        rst_n = 1'b1;
        tick();

        // Basic two-word load
        clr_counts();
        wbuf[0] = 16'h1201;
        wbuf[1] = 16'hB401;
        load(2, 0, 1'b0);
        tick();
        tick();
        chk("basic_hold", 32'(hold_cnt), 32'd4);
        chk("basic_done", 32'(done_cnt), 32'd1);
        chk("basic_hs", 32'(hs_cnt), 32'd4);
        peek(0, 16'h1201, "basic_w0");
        peek(1, 16'hB401, "basic_w1");
        peek(2, 16'h0000, "basic_w2");

        // Host gaps of three idle cycles between bytes
        clr_counts();
        load(2, 3, 1'b0);
        tick();
        chk("gap_hold", 32'(hold_cnt), 32'd13);
        chk("gap_done", 32'(done_cnt), 32'd1);
        chk("gap_hs", 32'(hs_cnt), 32'd4);
        peek(1, 16'hB401, "gap_w1");

        // Full sixteen-word load
        clr_counts();
        for (int k = 0; k < 16; k++) wbuf[k] = {8'(k), ~8'(k)};
        load(16, 0, 1'b0);
        tick();
        chk("full_hs", 32'(hs_cnt), 32'd32);
        chk("full_hold", 32'(hold_cnt), 32'd32);
        chk("full_done", 32'(done_cnt), 32'd1);
        for (int k = 0; k < 16; k++) peek(k, {8'(k), ~8'(k)}, "full_sweep");

        // Zero-count load
        clr_counts();
        do_start(0);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        tick();
        chk("zero_done_end", 32'(done), 32'd0);
        chk("zero_hold", 32'(hold_cnt), 32'd0);
        peek(5, 16'h05FA, "zero_mem");

        // Start during a load is ignored
        clr_counts();
        wbuf[0] = 16'hA55A;
        wbuf[1] = 16'h3C3C;
        load(2, 0, 1'b1);
        tick();
        chk("ign_hs", 32'(hs_cnt), 32'd4);
        peek(1, 16'h3C3C, "ign_w1");
        peek(2, 16'h02FD, "ign_w2");

        // Reset in the middle of a three-word load
        do_start(3);
        send_byte(8'h11, 0, 1'b0);
        send_byte(8'h22, 0, 1'b0);
        send_byte(8'h33, 0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_hold", 32'(cpu_hold), 32'd0);
        chk("mid_rst_ready", 32'(byte_ready), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        for (int a = 0; a < 16; a++) peek(a, 16'h0000, "mid_rst_mem");
        tick();
        rst_n = 1'b1;
        tick();
        wbuf[0] = 16'h7E81;
        load(1, 0, 1'b0);
        peek(0, 16'h7E81, "post_rst_w0");
        peek(1, 16'h0000, "post_rst_w1");

        // Reload preservation
        for (int i = 0; i < 3; i++) begin
            wbuf[i] = 16'($urandom);
            save[i] = wbuf[i];
        end
        load(3, 1, 1'b0);
        wbuf[0] = 16'hF200;
        load(1, 0, 1'b0);
        peek(0, 16'hF200, "reload_w0");
        peek(1, save[1], "reload_w1");
        peek(2, save[2], "reload_w2");

        // Randomized loads, back-to-back so some starts land in the done cycle
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < 16; i++) wbuf[i] = 16'($urandom);
            load(int'($urandom_range(0, 16)), int'($urandom_range(0, 2)), 1'($urandom));
            if ($urandom_range(0, 3) == 0) tick();
        end
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
